// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter
//   Shares the single reg_bank write port between the in-order pipeline
//   writeback and the multi-cycle MDU. The pipeline always wins. A busy
//   scoreboard of outstanding MDU destinations drives the ID-stage hazard
//   stall. A starvation counter forces a pipeline hold so that a waiting MDU
//   result is eventually written.
//
//   Ports
//     clk, rst_n                      clock, async active-low reset
//     pipe_wen_i/waddr_i/wdata_i      pipeline writeback request (never back-pressured)
//     mdu_valid_i/waddr_i/wdata_i     MDU result, held until mdu_ready_o
//     mdu_ready_o                     MDU write granted this cycle (combinational)
//     issue_en_i, issue_rd_i          MDU op issued from ID, marks rd busy
//     rs1_addr_i, rs2_addr_i          ID source registers
//     id_wen_i, id_rd_i               ID destination register
//     stall_o                         ID hazard stall (combinational)
//     pipe_hold_o                     pipeline must not write next cycle
//     reg_wen_o/waddr_o/wdata_o       registered reg_bank write port
//
//   state | meaning
//   IDLE  | no MDU result waiting, or it was granted on first try
//   WAIT  | MDU result valid but losing to the pipeline, wait_cnt counts losses
//   HOLD  | loss limit reached, pipeline held until the MDU result is written

module regbank_wb_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_wen_i,
  input  logic [ADDR_WIDTH-1:0] pipe_waddr_i,
  input  logic [WORD_WIDTH-1:0] pipe_wdata_i,
  input  logic                  mdu_valid_i,
  input  logic [ADDR_WIDTH-1:0] mdu_waddr_i,
  input  logic [WORD_WIDTH-1:0] mdu_wdata_i,
  output logic                  mdu_ready_o,
  input  logic                  issue_en_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                  id_wen_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  output logic                  stall_o,
  output logic                  pipe_hold_o,
  output logic                  reg_wen_o,
  output logic [ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [WORD_WIDTH-1:0] reg_wdata_o
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [NREGS-1:0]        busy_q, busy_d;
  logic                    reg_wen_q, reg_wen_d;
  logic [ADDR_WIDTH-1:0]   reg_waddr_q, reg_waddr_d;
  logic [WORD_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;

  logic pw;
  logic grant_mdu;
  logic raw_hit, waw_hit, inflight_hit;

  // x0 writes from the pipeline are dropped here so they cannot block the MDU
  assign pw          = pipe_wen_i && (pipe_waddr_i != '0);
  assign mdu_ready_o = mdu_valid_i && !pw;
  assign grant_mdu   = mdu_valid_i && mdu_ready_o;

  always_comb begin
    reg_wen_d   = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    if (pw) begin
      reg_wen_d   = 1'b1;
      reg_waddr_d = pipe_waddr_i;
      reg_wdata_d = pipe_wdata_i;
    end else if (grant_mdu) begin
      reg_wen_d   = (mdu_waddr_i != '0);
      reg_waddr_d = mdu_waddr_i;
      reg_wdata_d = mdu_wdata_i;
    end
  end

  // Set is applied after clear so a new issue to the same rd survives the
  // retirement of the previous op to that rd.
  always_comb begin
    busy_d = busy_q;
    if (grant_mdu) busy_d[mdu_waddr_i] = 1'b0;
    if (issue_en_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mdu_valid_i && !grant_mdu) begin
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (grant_mdu || !mdu_valid_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_ONE;
          if (wait_cnt_d == CNT_MAX) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // a pipe write during HOLD still wins; we simply keep holding
        if (grant_mdu || !mdu_valid_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      busy_q      <= '0;
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      reg_wen_q   <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  // busy[0] is held at 0, so index 0 can never raise a scoreboard hazard
  assign raw_hit      = busy_q[rs1_addr_i] | busy_q[rs2_addr_i];
  assign waw_hit      = id_wen_i & busy_q[id_rd_i];
  // the reg_bank write lands one cycle after arbitration, cover that gap
  assign inflight_hit = reg_wen_q && (reg_waddr_q != '0) &&
                        ((reg_waddr_q == rs1_addr_i) || (reg_waddr_q == rs2_addr_i));
  assign stall_o      = raw_hit | waw_hit | inflight_hit;

  assign pipe_hold_o  = (state_q == ST_HOLD);
  assign reg_wen_o    = reg_wen_q;
  assign reg_waddr_o  = reg_waddr_q;
  assign reg_wdata_o  = reg_wdata_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
module tb_regbank_wb_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wen_i = 1'b0;
  logic [4:0]  pipe_waddr_i = '0;
  logic [31:0] pipe_wdata_i = '0;
  logic        mdu_valid_i = 1'b0;
  logic [4:0]  mdu_waddr_i = '0;
  logic [31:0] mdu_wdata_i = '0;
  logic        mdu_ready_o;
  logic        issue_en_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic        id_wen_i = 1'b0;
  logic [4:0]  id_rd_i = '0;
  logic        stall_o;
  logic        pipe_hold_o;
  logic        reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_vec = 0;
  int n_err = 0;

  regbank_wb_arbiter #(.WORD_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen_i(pipe_wen_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_waddr_i(mdu_waddr_i), .mdu_wdata_i(mdu_wdata_i),
    .mdu_ready_o(mdu_ready_o),
    .issue_en_i(issue_en_i), .issue_rd_i(issue_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .id_wen_i(id_wen_i), .id_rd_i(id_rd_i),
    .stall_o(stall_o), .pipe_hold_o(pipe_hold_o),
    .reg_wen_o(reg_wen_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Registered outputs, busy set, and the length of the current run of
  // cycles in which a valid MDU result lost arbitration.
  logic        m_wen = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;
  int          m_lose = 0;

  logic m_pw, m_grant;
  assign m_pw    = pipe_wen_i && (pipe_waddr_i != 5'd0);
  assign m_grant = mdu_valid_i && !m_pw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wen  <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      m_busy <= '0;
      m_lose <= 0;
    end else begin
      if (m_pw) begin
        m_wen <= 1'b1; m_addr <= pipe_waddr_i; m_data <= pipe_wdata_i;
      end else if (m_grant) begin
        m_wen <= (mdu_waddr_i != 5'd0); m_addr <= mdu_waddr_i; m_data <= mdu_wdata_i;
      end else begin
        m_wen <= 1'b0;
      end
      if (m_grant) m_busy[mdu_waddr_i] <= 1'b0;
      if (issue_en_i && issue_rd_i != 5'd0) m_busy[issue_rd_i] <= 1'b1;
      m_lose <= (mdu_valid_i && !m_grant) ? m_lose + 1 : 0;
    end
  end

  // one compare per output on every falling edge
  always @(negedge clk) begin
    logic e_stall;
    e_stall = m_busy[rs1_addr_i] || m_busy[rs2_addr_i] ||
              (id_wen_i && m_busy[id_rd_i]) ||
              (m_wen && m_addr != 5'd0 && (m_addr == rs1_addr_i || m_addr == rs2_addr_i));
    check("cmp_ready", 64'(mdu_ready_o), 64'(m_grant));
    check("cmp_stall", 64'(stall_o), 64'(e_stall));
    check("cmp_hold",  64'(pipe_hold_o), 64'(m_lose >= MAX_WAIT));
    check("cmp_wen",   64'(reg_wen_o), 64'(m_wen));
    check("cmp_waddr", 64'(reg_waddr_o), 64'(m_addr));
    check("cmp_wdata", 64'(reg_wdata_o), 64'(m_data));
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3;
    check("rst_wen",   64'(reg_wen_o), 64'd0);
    check("rst_waddr", 64'(reg_waddr_o), 64'd0);
    check("rst_wdata", 64'(reg_wdata_o), 64'd0);
    check("rst_hold",  64'(pipe_hold_o), 64'd0);
    next(); rst_n = 1'b1;

    // pipe only, then a write to x0
    next(); pipe_wen_i = 1; pipe_waddr_i = 5'd7; pipe_wdata_i = 32'hDEADBEEF;
    next(); pipe_waddr_i = 5'd0; pipe_wdata_i = 32'h5555_5555;
    #3;
    check("t2_wen",   64'(reg_wen_o), 64'd1);
    check("t2_waddr", 64'(reg_waddr_o), 64'd7);
    check("t2_wdata", 64'(reg_wdata_o), 64'hDEADBEEF);
    next(); pipe_wen_i = 0;
    #3;
    check("t2_x0_wen",   64'(reg_wen_o), 64'd0);
    check("t2_x0_waddr", 64'(reg_waddr_o), 64'd7);

    // contention
    next(); pipe_wen_i = 1; pipe_waddr_i = 5'd3; pipe_wdata_i = 32'h33;
    mdu_valid_i = 1; mdu_waddr_i = 5'd9; mdu_wdata_i = 32'h1234;
    #3;
    check("t3_ready_lose", 64'(mdu_ready_o), 64'd0);
    next(); pipe_wen_i = 0;
    #3;
    check("t3_ready_win", 64'(mdu_ready_o), 64'd1);
    check("t3_pipe_addr", 64'(reg_waddr_o), 64'd3);
    next(); mdu_valid_i = 0;
    #3;
    check("t3_mdu_wen",   64'(reg_wen_o), 64'd1);
    check("t3_mdu_addr",  64'(reg_waddr_o), 64'd9);
    check("t3_mdu_data",  64'(reg_wdata_o), 64'h1234);

    // starvation
    next(); mdu_valid_i = 1; mdu_waddr_i = 5'd10; mdu_wdata_i = 32'hABCD;
    pipe_wen_i = 1; pipe_waddr_i = 5'd4;
    for (int k = 1; k <= 4; k++) begin
      pipe_wdata_i = 32'(k);
      #3;
      check("t4_no_hold", 64'(pipe_hold_o), 64'd0);
      next();
    end
    pipe_wen_i = 0;
    #3;
    check("t4_hold",       64'(pipe_hold_o), 64'd1);
    check("t4_ready",      64'(mdu_ready_o), 64'd1);
    check("t4_last_pipe",  64'(reg_wdata_o), 64'd4);
    next(); mdu_valid_i = 0;
    #3;
    check("t4_hold_drop",  64'(pipe_hold_o), 64'd0);
    check("t4_mdu_addr",   64'(reg_waddr_o), 64'd10);
    check("t4_mdu_data",   64'(reg_wdata_o), 64'hABCD);

    // hazards
    next(); issue_en_i = 1; issue_rd_i = 5'd12;
    next(); issue_en_i = 0; rs1_addr_i = 5'd12;
    #3; check("t5_raw", 64'(stall_o), 64'd1);
    next(); rs1_addr_i = 5'd0; id_wen_i = 1; id_rd_i = 5'd12;
    #3; check("t5_waw", 64'(stall_o), 64'd1);
    next(); id_wen_i = 0;
    #3; check("t5_no_waw", 64'(stall_o), 64'd0);
    next(); rs1_addr_i = 5'd12; mdu_valid_i = 1; mdu_waddr_i = 5'd12; mdu_wdata_i = 32'h77;
    #3; check("t5_grant_cycle", 64'(stall_o), 64'd1);
    next(); mdu_valid_i = 0;
    #3; check("t5_inflight", 64'(stall_o), 64'd1);
    next();
    #3; check("t5_clear", 64'(stall_o), 64'd0);

    // same-cycle set/clear
    next(); rs1_addr_i = 5'd0; issue_en_i = 1; issue_rd_i = 5'd12;
    next(); mdu_valid_i = 1; mdu_waddr_i = 5'd12; mdu_wdata_i = 32'h88;
    #3; check("t6_ready", 64'(mdu_ready_o), 64'd1);
    next(); issue_en_i = 0; mdu_valid_i = 0; rs1_addr_i = 5'd12;
    #3; check("t6_stall_a", 64'(stall_o), 64'd1);
    next();
    #3;
    check("t6_stall_b", 64'(stall_o), 64'd1);
    check("t6_wen",     64'(reg_wen_o), 64'd0);
    next(); rs1_addr_i = 5'd0; mdu_valid_i = 1; mdu_waddr_i = 5'd12; mdu_wdata_i = 32'h99;
    next(); mdu_valid_i = 0; issue_en_i = 1; issue_rd_i = 5'd5;

    // reset in the middle of HOLD with busy[5] set
    next(); issue_en_i = 0; rs2_addr_i = 5'd5;
    mdu_valid_i = 1; mdu_waddr_i = 5'd9; mdu_wdata_i = 32'h4321;
    pipe_wen_i = 1; pipe_waddr_i = 5'd4; pipe_wdata_i = 32'hCAFE0004;
    repeat (4) next();
    #3;
    check("t1_pre_hold",  64'(pipe_hold_o), 64'd1);
    check("t1_pre_stall", 64'(stall_o), 64'd1);
    pipe_wen_i = 0; mdu_valid_i = 0; rst_n = 1'b0;
    #2;
    check("t1_wen",   64'(reg_wen_o), 64'd0);
    check("t1_waddr", 64'(reg_waddr_o), 64'd0);
    check("t1_wdata", 64'(reg_wdata_o), 64'd0);
    check("t1_hold",  64'(pipe_hold_o), 64'd0);
    check("t1_stall", 64'(stall_o), 64'd0);
    next(); rst_n = 1'b1;
    next();
    #3;
    check("t1_post_hold",  64'(pipe_hold_o), 64'd0);
    check("t1_post_stall", 64'(stall_o), 64'd0);
    repeat (2) next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
